// File: rtl/mem_stage.sv
// mem_stage: MEM stage of the 5-stage MIPS pipeline.
// Issues loads/stores over a req/ack handshake, resolves the branch decision
// and holds the MEM/WB pipeline register. All state updates on the falling edge.
module mem_stage #(
  parameter int unsigned SIZE = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  // EX/MEM inputs
  input  logic [SIZE-1:0] ALUResult,
  input  logic [SIZE-1:0] readData2,
  input  logic [4:0]      writeReg,
  input  logic            MemRead,
  input  logic            MemWrite,
  input  logic            Branch,
  input  logic            zeroFlag,
  input  logic            RegWrite,
  input  logic            MemToReg,
  input  logic [SIZE-1:0] branchTarget,
  // Data-memory handshake
  output logic            mem_req,
  output logic            mem_we,
  output logic [SIZE-1:0] mem_addr,
  output logic [SIZE-1:0] mem_wdata,
  input  logic [SIZE-1:0] mem_rdata,
  input  logic            mem_ack,
  // Pipeline control
  output logic            hit,
  output logic            PCSrc,
  output logic [SIZE-1:0] branchTarget_Out,
  // MEM/WB register
  output logic [SIZE-1:0] readData_Out,
  output logic [SIZE-1:0] ALUResult_Out,
  output logic [4:0]      writeReg_Out,
  output logic            RegWrite_Out,
  output logic            MemToReg_Out
);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e          r_state;
  state_e          w_state_next;
  logic            w_hit;
  logic            w_memop;

  logic            r_mem_req;
  logic            r_mem_we;
  logic [SIZE-1:0] r_mem_addr;
  logic [SIZE-1:0] r_mem_wdata;
  logic [SIZE-1:0] r_load_buf;

  logic [SIZE-1:0] r_read_data;
  logic [SIZE-1:0] r_alu_result;
  logic [4:0]      r_write_reg;
  logic            r_reg_write;
  logic            r_mem_to_reg;

  assign w_memop = MemRead | MemWrite;

  // Branch resolution is independent of the access FSM.
  assign PCSrc            = Branch & zeroFlag;
  assign branchTarget_Out = branchTarget;

  // Next-state and stall decode.
  always_comb begin
    w_state_next = r_state;
    w_hit        = 1'b1;
    unique case (r_state)
      StIdle: begin
        w_hit = ~w_memop;
        if (w_memop) w_state_next = StBusy;
      end
      StBusy: begin
        w_hit = 1'b0;
        if (mem_ack) w_state_next = StDone;
      end
      StDone: begin
        w_hit        = 1'b1;
        w_state_next = StIdle;
      end
      default: begin
        w_hit        = 1'b1;
        w_state_next = StIdle;
      end
    endcase
  end

  // FSM state register.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Memory request registers; address/data stay frozen while the access is pending.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_load_buf  <= '0;
    end else begin
      if (r_state == StIdle && w_memop) begin
        r_mem_req   <= 1'b1;
        // A simultaneous read+write is treated as a write.
        r_mem_we    <= MemWrite;
        r_mem_addr  <= {ALUResult[SIZE-1:2], 2'b00};
        r_mem_wdata <= readData2;
      end else if (r_state == StBusy && mem_ack) begin
        r_mem_req  <= 1'b0;
        r_load_buf <= r_mem_we ? '0 : mem_rdata;
      end
    end
  end

  // MEM/WB register: load on hit, bubble the control bits on stall.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_read_data  <= '0;
      r_alu_result <= '0;
      r_write_reg  <= '0;
      r_reg_write  <= 1'b0;
      r_mem_to_reg <= 1'b0;
    end else if (w_hit) begin
      // hit in IDLE implies no memory op; only DONE carries load data.
      r_read_data  <= (r_state == StDone) ? r_load_buf : '0;
      r_alu_result <= ALUResult;
      r_write_reg  <= writeReg;
      r_reg_write  <= RegWrite;
      r_mem_to_reg <= MemToReg;
    end else begin
      r_reg_write  <= 1'b0;
      r_mem_to_reg <= 1'b0;
    end
  end

  assign hit           = w_hit;
  assign mem_req       = r_mem_req;
  assign mem_we        = r_mem_we;
  assign mem_addr      = r_mem_addr;
  assign mem_wdata     = r_mem_wdata;
  assign readData_Out  = r_read_data;
  assign ALUResult_Out = r_alu_result;
  assign writeReg_Out  = r_write_reg;
  assign RegWrite_Out  = r_reg_write;
  assign MemToReg_Out  = r_mem_to_reg;

endmodule

// File: tb/tb_mem_stage.sv
// Testbench for mem_stage: directed cases plus a random instruction stream,
// checked against a per-instruction timeline model.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] ALUResult, readData2, branchTarget, mem_rdata;
  logic [4:0]  writeReg;
  logic        MemRead, MemWrite, Branch, zeroFlag, RegWrite, MemToReg, mem_ack;
  logic        mem_req, mem_we, hit, PCSrc, RegWrite_Out, MemToReg_Out;
  logic [31:0] mem_addr, mem_wdata, branchTarget_Out, readData_Out, ALUResult_Out;
  logic [4:0]  writeReg_Out;

  int n_vec = 0;
  int n_err = 0;

  // Expected MEM/WB contents.
  logic [31:0] exp_rd, exp_alu;
  logic [4:0]  exp_wr;
  logic        exp_rw, exp_m2r;

  mem_stage #(.SIZE(32)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .ALUResult        (ALUResult),
    .readData2        (readData2),
    .writeReg         (writeReg),
    .MemRead          (MemRead),
    .MemWrite         (MemWrite),
    .Branch           (Branch),
    .zeroFlag         (zeroFlag),
    .RegWrite         (RegWrite),
    .MemToReg         (MemToReg),
    .branchTarget     (branchTarget),
    .mem_req          (mem_req),
    .mem_we           (mem_we),
    .mem_addr         (mem_addr),
    .mem_wdata        (mem_wdata),
    .mem_rdata        (mem_rdata),
    .mem_ack          (mem_ack),
    .hit              (hit),
    .PCSrc            (PCSrc),
    .branchTarget_Out (branchTarget_Out),
    .readData_Out     (readData_Out),
    .ALUResult_Out    (ALUResult_Out),
    .writeReg_Out     (writeReg_Out),
    .RegWrite_Out     (RegWrite_Out),
    .MemToReg_Out     (MemToReg_Out)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_memwb(input string tag);
    check_eq({tag, ".readData_Out"},  readData_Out,          exp_rd);
    check_eq({tag, ".ALUResult_Out"}, ALUResult_Out,         exp_alu);
    check_eq({tag, ".writeReg_Out"},  {27'd0, writeReg_Out}, {27'd0, exp_wr});
    check_eq({tag, ".RegWrite_Out"},  {31'd0, RegWrite_Out}, {31'd0, exp_rw});
    check_eq({tag, ".MemToReg_Out"},  {31'd0, MemToReg_Out}, {31'd0, exp_m2r});
  endtask

  // Present one instruction from EX/MEM until it retires. Called just after a
  // falling edge. n = BUSY cycle on which the memory acks (memory ops only).
  task automatic run_instr(input logic [31:0] alu, input logic [31:0] wd2, input logic [4:0] wr,
                           input logic mr, input logic mw, input logic rw, input logic m2r,
                           input int n, input logic [31:0] rdata);
    logic memop;
    int   cycles;
    logic br, zf;
    logic [31:0] bt;
    memop  = mr | mw;
    cycles = memop ? n + 2 : 1;
    ALUResult = alu; readData2 = wd2; writeReg = wr;
    MemRead = mr; MemWrite = mw; RegWrite = rw; MemToReg = m2r;
    for (int c = 0; c < cycles; c++) begin
      br = 1'($urandom_range(0, 1));
      zf = 1'($urandom_range(0, 1));
      bt = $urandom;
      Branch = br; zeroFlag = zf; branchTarget = bt;
      // Ack outside BUSY is noise that must be ignored.
      if (memop && c == n)                     mem_ack = 1'b1;
      else if (!memop || c == 0 || c == n + 1) mem_ack = 1'($urandom_range(0, 1));
      else                                     mem_ack = 1'b0;
      mem_rdata = (memop && c == n) ? rdata : $urandom;
      #1;
      check_eq("hit", {31'd0, hit}, {31'd0, (!memop || c == cycles - 1)});
      check_eq("PCSrc", {31'd0, PCSrc}, {31'd0, br & zf});
      check_eq("branchTarget_Out", branchTarget_Out, bt);
      check_eq("mem_req", {31'd0, mem_req}, {31'd0, (memop && c >= 1 && c <= n)});
      if (memop && c >= 1 && c <= n) begin
        check_eq("mem_addr", mem_addr, {alu[31:2], 2'b00});
        check_eq("mem_we", {31'd0, mem_we}, {31'd0, mw});
        check_eq("mem_wdata", mem_wdata, wd2);
      end
      @(negedge clk);
      #1;
      if (c == cycles - 1) begin
        exp_alu = alu; exp_wr = wr; exp_rw = rw; exp_m2r = m2r;
        exp_rd  = (memop && !mw) ? rdata : 32'd0;
      end else begin
        exp_rw = 1'b0; exp_m2r = 1'b0;
      end
      check_memwb(c == cycles - 1 ? "retire" : "bubble");
    end
    mem_ack = 1'b0;
  endtask

  task automatic drive_nop();
    ALUResult = '0; readData2 = '0; writeReg = '0; MemRead = 0; MemWrite = 0;
    RegWrite = 0; MemToReg = 0; Branch = 0; zeroFlag = 0; branchTarget = '0;
    mem_ack = 0; mem_rdata = '0;
  endtask

  initial begin
    int kind;
    rst_n = 1'b0;
    drive_nop();
    exp_rd = '0; exp_alu = '0; exp_wr = '0; exp_rw = 0; exp_m2r = 0;
    #3;
    // Reset state.
    check_eq("rst.hit", {31'd0, hit}, 32'd1);
    check_eq("rst.mem_req", {31'd0, mem_req}, 32'd0);
    check_eq("rst.mem_we", {31'd0, mem_we}, 32'd0);
    check_eq("rst.mem_addr", mem_addr, 32'd0);
    check_eq("rst.mem_wdata", mem_wdata, 32'd0);
    check_eq("rst.PCSrc", {31'd0, PCSrc}, 32'd0);
    check_memwb("rst");
    #12 rst_n = 1'b1;
    @(negedge clk);
    #1;

    // Branch resolution, same cycle.
    Branch = 1; zeroFlag = 1; branchTarget = 32'h40;
    #1;
    check_eq("br.PCSrc", {31'd0, PCSrc}, 32'd1);
    check_eq("br.target", branchTarget_Out, 32'h40);
    zeroFlag = 0;
    #1;
    check_eq("br.PCSrc_nz", {31'd0, PCSrc}, 32'd0);
    @(negedge clk);
    #1;
    exp_rw = 0; exp_m2r = 0;

    // R-type, load with 3 BUSY cycles, store with immediate ack.
    run_instr(32'h1234, 32'h0, 5'd5, 0, 0, 1, 0, 0, 32'h0);
    run_instr(32'h103, 32'h0, 5'd7, 1, 0, 1, 1, 3, 32'hDEADBEEF);
    run_instr(32'h20, 32'h55, 5'd0, 0, 1, 0, 0, 1, 32'h0);

    // Reset in the middle of an access, then a late ack.
    ALUResult = 32'h200; MemRead = 1; RegWrite = 1; MemToReg = 1; writeReg = 5'd9;
    mem_ack = 0;
    @(negedge clk);
    #1;
    check_eq("midrst.req_busy", {31'd0, mem_req}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check_eq("midrst.req_drop", {31'd0, mem_req}, 32'd0);
    drive_nop();
    exp_rd = '0; exp_alu = '0; exp_wr = '0; exp_rw = 0; exp_m2r = 0;
    check_memwb("midrst");
    #1 rst_n = 1'b1;
    mem_ack = 1; mem_rdata = 32'h0BAD0BAD;
    #1;
    check_eq("late.hit", {31'd0, hit}, 32'd1);
    @(negedge clk);
    #1;
    mem_ack = 0;
    check_eq("late.req", {31'd0, mem_req}, 32'd0);
    check_memwb("late");

    // Random instruction stream, back-to-back memory ops included.
    for (int i = 0; i < 60; i++) begin
      kind = int'($urandom_range(0, 3));
      run_instr($urandom, $urandom, 5'($urandom_range(0, 31)),
                kind == 1 || kind == 3, kind >= 2,
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                int'($urandom_range(1, 4)), $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Watchdog: never hang.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
